datapath_div: RTL

//  Iterative restoring divider: A/Q/M register datapath plus control FSM.

---
 rtl/datapath_div.sv | 122 ++++++++++++
 1 files changed

// File: rtl/datapath_div.sv
// Iterative restoring divider: A/Q/M register datapath plus IDLE/RUN/DONE control, one quotient bit per clock.
// Optional feature: define DIV_STICKY_EN to register sticky = |remainder for FP rounding; otherwise sticky is tied to 0.
module datapath_div #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] inQ,
  input  logic [WIDTH-1:0] inM,
  output logic [WIDTH-1:0] outQ_res,
  output logic [WIDTH-1:0] outA_res,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             sticky
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic [CNT_W-1:0] count;

  // The shifted partial remainder and trial difference carry one extra bit for the sign;
  // the restored remainder is always below M, so A itself needs only WIDTH bits of storage.
  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] q_next;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    a_shift = '0;
    diff    = '0;
    q_bit   = 1'b0;
    a_next  = '0;
    q_next  = '0;

    a_shift = {a_reg, q_reg[WIDTH-1]};
    diff    = a_shift - {1'b0, m_reg};
    q_bit   = ~diff[WIDTH];
    a_next  = q_bit ? diff[WIDTH-1:0] : a_shift[WIDTH-1:0];
    q_next  = {q_reg[WIDTH-2:0], q_bit};
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      a_reg       <= '0;
      q_reg       <= '0;
      m_reg       <= '0;
      count       <= '0;
      outQ_res    <= '0;
      outA_res    <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (inM != '0) begin
              a_reg <= '0;
              q_reg <= inQ;
              m_reg <= inM;
              count <= '0;
              state <= RUN;
            end else begin
              outQ_res    <= '1;
              outA_res    <= inQ;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end
          end
        end
        RUN: begin
          a_reg <= a_next;
          q_reg <= q_next;
          count <= count + 1'b1;
          if (count == LAST_ITER) begin
            outQ_res    <= q_next;
            outA_res    <= a_next;
            div_by_zero <= 1'b0;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIV_STICKY_EN
  logic sticky_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_reg <= 1'b0;
    end else if (state == IDLE && start && inM == '0) begin
      sticky_reg <= 1'b0;
    end else if (state == RUN && count == LAST_ITER) begin
      sticky_reg <= |a_next;
    end
  end

  assign sticky = sticky_reg;
`else
  assign sticky = 1'b0;
`endif

endmodule
